// File: rtl/bus_pkg.sv
// Shared constants for the bus loader: load/bus codes, default widths,
// register bit indices and the memory-write FSM state type.
package bus_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // Bit positions inside inr_vec / clr_vec
  localparam int IDX_AR   = 0;
  localparam int IDX_PC   = 1;
  localparam int IDX_DR   = 2;
  localparam int IDX_AC   = 3;
  localparam int IDX_IR   = 4;
  localparam int IDX_TR   = 5;
  localparam int NUM_REGS = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

  // Register at bit index idx is loaded by bus code idx+1.
  function automatic logic [2:0] code_of(input int idx);
    return 3'(idx + 1);
  endfunction

endpackage

// File: rtl/reg_cell.sv
// Width-parameterised register with clear, load and increment controls.
// Clear wins over load, load wins over increment; increment wraps naturally.
module reg_cell #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         inr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = d;
    end else if (inr) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bus_loader.sv
// Common-bus register loader: six registers fed from bus_data plus a
// single-entry memory write port with request/acknowledge handshake.
module bus_loader
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_data,
  input  logic [2:0]        load_code,
  input  logic              load_valid,
  input  logic [5:0]        inr_vec,
  input  logic [5:0]        clr_vec,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] ar_outdata,
  output logic [ADDR_W-1:0] pc_outdata,
  output logic [DATA_W-1:0] dr_outdata,
  output logic [DATA_W-1:0] ac_outdata,
  output logic [DATA_W-1:0] ir_outdata,
  output logic [DATA_W-1:0] tr_outdata,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              load_err
);

  logic [ADDR_W-1:0] addr_reg_q [2];
  logic [DATA_W-1:0] data_reg_q [4];

  // AR and PC take only the low address bits of the bus
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_addr_reg
      reg_cell #(
        .W (ADDR_W)
      ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_vec[IDX_AR + gi]),
        .ld    (load_valid && (load_code == code_of(IDX_AR + gi))),
        .inr   (inr_vec[IDX_AR + gi]),
        .d     (bus_data[ADDR_W-1:0]),
        .q     (addr_reg_q[gi])
      );
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_data_reg
      reg_cell #(
        .W (DATA_W)
      ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_vec[IDX_DR + gi]),
        .ld    (load_valid && (load_code == code_of(IDX_DR + gi))),
        .inr   (inr_vec[IDX_DR + gi]),
        .d     (bus_data),
        .q     (data_reg_q[gi])
      );
    end
  endgenerate

  assign ar_outdata = addr_reg_q[IDX_AR];
  assign pc_outdata = addr_reg_q[IDX_PC];
  assign dr_outdata = data_reg_q[IDX_DR - IDX_DR];
  assign ac_outdata = data_reg_q[IDX_AC - IDX_DR];
  assign ir_outdata = data_reg_q[IDX_IR - IDX_DR];
  assign tr_outdata = data_reg_q[IDX_TR - IDX_DR];

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q, err_d;
  logic              mem_load;

  assign mem_load = load_valid && (load_code == BUS_MEM);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = load_valid && (load_code == BUS_NONE);
    unique case (state_q)
      ST_IDLE: begin
        // AR is captured before any same-cycle AR update takes effect
        if (mem_load) begin
          wr_addr_d = addr_reg_q[IDX_AR];
          wr_data_d = bus_data;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_load) begin
          err_d = 1'b1;
        end
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign busy        = (state_q == ST_WRITE);
  assign mem_wr_req  = busy;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign load_err    = err_q;

endmodule

// File: tb/tb_bus_loader.sv
// Scoreboard bench for bus_loader: a stimulus task drives inputs and pushes
// the expected next-cycle outputs; a monitor pops and compares every cycle.
module tb_bus_loader;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] bus_data;
  logic [2:0]    load_code;
  logic          load_valid;
  logic [5:0]    inr_vec;
  logic [5:0]    clr_vec;
  logic          mem_ack;
  logic [AW-1:0] ar_outdata, pc_outdata, mem_wr_addr;
  logic [DW-1:0] dr_outdata, ac_outdata, ir_outdata, tr_outdata, mem_wr_data;
  logic          mem_wr_req, busy, load_err;

  always #5 clk = ~clk;

  bus_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_data    (bus_data),
    .load_code   (load_code),
    .load_valid  (load_valid),
    .inr_vec     (inr_vec),
    .clr_vec     (clr_vec),
    .mem_ack     (mem_ack),
    .ar_outdata  (ar_outdata),
    .pc_outdata  (pc_outdata),
    .dr_outdata  (dr_outdata),
    .ac_outdata  (ac_outdata),
    .ir_outdata  (ir_outdata),
    .tr_outdata  (tr_outdata),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .load_err    (load_err)
  );

  typedef struct {
    int unsigned edge_no;
    int          r0, r1, r2, r3, r4, r5;
    bit          pend;
    int          addr;
    int          data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_cnt    = 0;
  int          vectors     = 0;
  int          n_cmp       = 0;
  int          miscompares = 0;

  // Reference model: register file, pending-write flag and captured write
  int m_reg[6];
  bit m_pend;
  int m_addr, m_data;
  bit m_err;

  always @(posedge clk) edge_cnt++;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", nm, edge_cnt, got, want);
    end
  endtask

  task automatic step(input bit rn, input int bus, input int code, input bit lv,
                      input int inr, input int clr, input bit ack);
    exp_t e;
    int   nxt[6];
    int   modv;
    @(negedge clk);
    rst_n      = rn;
    bus_data   = 16'(bus);
    load_code  = 3'(code);
    load_valid = lv;
    inr_vec    = 6'(inr);
    clr_vec    = 6'(clr);
    mem_ack    = ack;
    vectors++;
    if (!rn) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_pend = 0; m_addr = 0; m_data = 0; m_err = 0;
    end else begin
      m_err = lv && (code == 0 || (code == 7 && m_pend));
      if (lv && code == 7 && !m_pend) begin
        m_addr = m_reg[0];
        m_data = bus & 16'hFFFF;
        m_pend = 1;
      end else if (m_pend && ack) begin
        m_pend = 0;
      end
      for (int i = 0; i < 6; i++) begin
        modv = (i < 2) ? (1 << AW) : (1 << DW);
        if (((clr >> i) & 1) != 0)              nxt[i] = 0;
        else if (lv && code == i + 1)           nxt[i] = (bus & 16'hFFFF) % modv;
        else if (((inr >> i) & 1) != 0)        nxt[i] = (m_reg[i] + 1) % modv;
        else                                    nxt[i] = m_reg[i];
      end
      foreach (m_reg[i]) m_reg[i] = nxt[i];
    end
    e.edge_no = edge_cnt + 1;
    e.r0 = m_reg[0]; e.r1 = m_reg[1]; e.r2 = m_reg[2];
    e.r3 = m_reg[3]; e.r4 = m_reg[4]; e.r5 = m_reg[5];
    e.pend = m_pend; e.addr = m_addr; e.data = m_data; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
      e = sb.pop_front();
      cmp("ar",       32'(ar_outdata),  32'(e.r0));
      cmp("pc",       32'(pc_outdata),  32'(e.r1));
      cmp("dr",       32'(dr_outdata),  32'(e.r2));
      cmp("ac",       32'(ac_outdata),  32'(e.r3));
      cmp("ir",       32'(ir_outdata),  32'(e.r4));
      cmp("tr",       32'(tr_outdata),  32'(e.r5));
      cmp("wr_req",   32'(mem_wr_req),  32'(e.pend));
      cmp("busy",     32'(busy),        32'(e.pend));
      cmp("wr_addr",  32'(mem_wr_addr), 32'(e.addr));
      cmp("wr_data",  32'(mem_wr_data), 32'(e.data));
      cmp("load_err", 32'(load_err),    32'(e.err));
    end
  end

  initial begin
    int code, bus;
    rst_n = 0; bus_data = '0; load_code = '0; load_valid = 0;
    inr_vec = '0; clr_vec = '0; mem_ack = 0;

    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 16'hFFFF, 7, 1, 6'h3F, 0, 1);
    settle();
    cmp("rst_ar", 32'(ar_outdata), 0);
    cmp("rst_ac", 32'(ac_outdata), 0);
    cmp("rst_req", 32'(mem_wr_req), 0);
    cmp("rst_err", 32'(load_err), 0);

    // PC load discards upper bus bits
    step(1, 16'hABCD, 2, 1, 0, 0, 0);
    settle();
    cmp("pc_load", 32'(pc_outdata), 32'h0BCD);
    cmp("pc_load_ar", 32'(ar_outdata), 0);

    // AC wrap, then clear beats load and increment
    step(1, 16'hFFFF, 4, 1, 0, 0, 0);
    step(1, 0, 0, 0, 6'h08, 0, 0);
    settle();
    cmp("ac_wrap", 32'(ac_outdata), 0);
    step(1, 0, 0, 0, 6'h08, 0, 0);
    step(1, 16'h1234, 4, 1, 6'h08, 6'h08, 0);
    settle();
    cmp("ac_clr_prio", 32'(ac_outdata), 0);

    // Memory write with same-cycle AR increment
    step(1, 16'h0010, 1, 1, 0, 0, 0);
    step(1, 16'h5A5A, 7, 1, 6'h01, 0, 0);
    settle();
    cmp("mw_req", 32'(mem_wr_req), 1);
    cmp("mw_addr", 32'(mem_wr_addr), 32'h010);
    cmp("mw_data", 32'(mem_wr_data), 32'h5A5A);
    cmp("mw_ar", 32'(ar_outdata), 32'h011);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 16'h1111, 7, 1, 0, 0, 0);
    settle();
    cmp("busy_err", 32'(load_err), 1);
    cmp("busy_data", 32'(mem_wr_data), 32'h5A5A);
    step(1, 0, 0, 0, 0, 0, 1);
    settle();
    cmp("ack_req", 32'(mem_wr_req), 0);
    cmp("err_once", 32'(load_err), 0);

    // Code 0 rejected
    step(1, 16'hBEEF, 0, 1, 0, 0, 0);
    settle();
    cmp("code0_err", 32'(load_err), 1);
    cmp("code0_ar", 32'(ar_outdata), 32'h011);
    step(1, 0, 0, 0, 0, 0, 0);
    settle();
    cmp("code0_pulse", 32'(load_err), 0);

    // Reset during WRITE
    step(1, 16'h0020, 1, 1, 0, 0, 0);
    step(1, 16'h7777, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    settle();
    cmp("rstw_req", 32'(mem_wr_req), 0);
    cmp("rstw_busy", 32'(busy), 0);
    cmp("rstw_data", 32'(mem_wr_data), 0);
    step(1, 0, 0, 0, 0, 0, 1);
    settle();
    cmp("rstw_ack", 32'(mem_wr_req), 0);

    for (int n = 0; n < 800; n++) begin
      code = int'($urandom_range(0, 7));
      bus  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : int'($urandom() & 32'hFFFF);
      step($urandom_range(0, 59) != 0, bus, code, $urandom_range(0, 3) != 0,
           int'($urandom() & $urandom() & 32'h3F),
           int'($urandom() & $urandom() & $urandom() & 32'h3F),
           $urandom_range(0, 2) == 0);
    end

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
